// File: rtl/cnt3_arb_pkg.sv
// rtl/cnt3_arb_pkg.sv - shared types and constants for the 3-bit step arbiter
package cnt3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        REJ  = 2'd2
    } state_t;

    localparam logic [2:0] CNT_MAX  = 3'd7;
    localparam logic [2:0] CNT_MIN  = 3'd0;
    localparam logic       DIR_UP   = 1'b1;
    localparam logic       DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_cnt3.sv
// rtl/updown_cnt3.sv - 3-bit up/down counter with boundary detection
module updown_cnt3
    import cnt3_arb_pkg::*;
#(
    parameter bit WRAP_EN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_en,
    input  logic       down_en,
    output logic [2:0] value,
    output logic       at_bound
);

    logic step_up;
    logic step_down;

    assign step_up   = up_en && !down_en;
    assign step_down = down_en && !up_en;

    // High when the requested step would cross 7->0 or 0->7.
    assign at_bound = (step_up && (value == CNT_MAX)) ||
                      (step_down && (value == CNT_MIN));

    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= CNT_MIN;
        end else if ((step_up || step_down) && (!at_bound || WRAP_EN)) begin
            value <= step_up ? value + 3'd1 : value - 3'd1;
        end
    end

endmodule

// File: rtl/cnt3_step_arbiter.sv
// rtl/cnt3_step_arbiter.sv - round-robin four-phase arbiter for a shared 3-bit counter
module cnt3_step_arbiter
    import cnt3_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter bit WRAP_EN = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] dir,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] rej,
    output logic [2:0]      count,
    output logic            full,
    output logic            empty,
    output logic            busy,
    output logic            wrap
);

    state_t          state, state_n;
    logic [1:0]      ptr, ptr_n;
    logic [1:0]      w, w_n;
    logic [1:0]      win;
    logic            found;
    int              idx;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] win_mask;
    logic [NREQ-1:0] w_mask;
    logic            arb;
    logic            win_up;
    logic            up_en;
    logic            down_en;
    logic            at_bound;

    // Lowest rotated offset from ptr wins, so iterate downward and let i=0 land last.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 0;
        cand  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx  = (int'(ptr) + i) % NREQ;
            cand = NREQ'(1) << idx;
            if (|(req & cand)) begin
                found = 1'b1;
                win   = idx[1:0];
            end
        end
    end

    assign win_mask = NREQ'(1) << win;
    assign w_mask   = NREQ'(1) << w;
    assign arb      = (state == IDLE) && found;
    assign win_up   = |(dir & win_mask);
    assign up_en    = arb && (win_up == DIR_UP);
    assign down_en  = arb && (win_up == DIR_DOWN);

    updown_cnt3 #(.WRAP_EN(WRAP_EN)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .up_en    (up_en),
        .down_en  (down_en),
        .value    (count),
        .at_bound (at_bound)
    );

    assign full  = (count == CNT_MAX);
    assign empty = (count == CNT_MIN);

    always_comb begin
        state_n = state;
        w_n     = w;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    w_n     = win;
                    state_n = (at_bound && !WRAP_EN) ? REJ : GNT;
                end
            end
            GNT, REJ: begin
                if (!(|(req & w_mask))) begin
                    state_n = IDLE;
                    ptr_n   = (w == 2'(NREQ - 1)) ? 2'd0 : w + 2'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            w     <= 2'd0;
            gnt   <= '0;
            rej   <= '0;
            wrap  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            w     <= w_n;
            gnt   <= (state_n == GNT) ? (NREQ'(1) << w_n) : '0;
            rej   <= (state_n == REJ) ? (NREQ'(1) << w_n) : '0;
            wrap  <= arb && at_bound && WRAP_EN;
            busy  <= (state_n != IDLE);
        end
    end

endmodule

// File: doc/cnt3_step_arbiter.md
# cnt3_step_arbiter

Arbiter and sequencer for a shared 3-bit up/down counter. Several requesters each ask for a single up or down step. A round-robin four-phase handshake grants exactly one step per transaction. The block owns the counter register, exports count, full and empty, and refuses steps that would wrap unless wrapping is enabled.

## Interface
- NREQ, default 2: number of requesters, range 2..4.
- WRAP_EN, default 0: 0 means an up step at 7 or a down step at 0 is rejected; 1 means the counter wraps modulo 8.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  NREQ  per-requester request level; held until gnt or rej is seen, then dropped.
- dir  in  NREQ  per-requester direction; 1 = up, 0 = down; sampled only in the arbitration cycle.
- gnt  out  NREQ  one-hot grant level; the step has been applied.
- rej  out  NREQ  one-hot reject level; the step was refused at a boundary.
- count  out  3  current counter value.
- full  out  1  count == 7.
- empty  out  1  count == 0.
- busy  out  1  FSM not in IDLE.
- wrap  out  1  one-cycle pulse when an applied step wrapped (only possible with WRAP_EN=1).

## Operation
- FSM states: IDLE, GNT, REJ.
- IDLE, any req bit set:
  - Select winner w: the first set bit searching upward from round-robin pointer ptr, modulo NREQ.
  - Latch w and dir[w].
  - Boundary case (dir up at 7, or dir down at 0) with WRAP_EN=0: go to REJ; count unchanged.
  - Otherwise: apply the step to count (+1 or -1 mod 8) and go to GNT.
  - If the step wrapped, assert wrap.
- GNT: gnt[w]=1 while req[w]=1. When req[w]=0: go to IDLE, ptr <= (w+1) mod NREQ.
- REJ: rej[w]=1 while req[w]=1. When req[w]=0: go to IDLE, ptr <= (w+1) mod NREQ.
- Requests from other requesters are ignored while busy. They stay pending and compete at the next IDLE cycle.
- Changes to dir[w] during GNT/REJ are ignored. Exactly one step is applied per transaction.
- full and empty are combinational decodes of the count register.
- Reset values (rst=0 at an edge): count=0, ptr=0, state=IDLE, gnt=0, rej=0, wrap=0, busy=0, full=0, empty=1.
- Reset has priority over every transition. Reset mid-transaction aborts it and drops gnt/rej in the next cycle.
- A winner that drops req in the same cycle it is arbitrated still receives its step. gnt then pulses for one cycle.

## Timing
- req[w] is sampled at edge E0 in IDLE. At E0: count updates, and gnt or rej registers high; both are visible in the cycle after E0. Latency: one cycle.
- Requester drops req[w] before edge E1: gnt/rej clear at E1. The next arbitration can happen at E2. Minimum two cycles per transaction.
- wrap is high only for the single cycle following the wrapping edge.
- All outputs are registered except full and empty.

## Structure
- Package cnt3_arb_pkg holds:
  - the state enum (IDLE, GNT, REJ);
  - CNT_MAX = 3'd7 and CNT_MIN = 3'd0;
  - DIR_UP = 1'b1 and DIR_DOWN = 1'b0.
- Sub-module updown_cnt3 contains the 3-bit counter register:
  - inputs: clk, rst (sync active-low), up_en, down_en;
  - up_en and down_en both high, or both low, holds the value;
  - outputs: value and a boundary flag.
- The top level contains the FSM, the round-robin pointer, the winner selection and the handshake outputs.

## Test plan
All scenarios use NREQ=2.
- Reset: rst=0 for 2 cycles while req=2'b11 → count=0, empty=1, gnt=0, busy=0.
- Single up (WRAP_EN=0): req[0]=1, dir[0]=1 at count=3 → next cycle gnt=2'b01, count=4. After req[0] drops, gnt clears and busy returns to 0.
- Round robin: req=2'b11, both dir=1, each requester drops req on seeing its grant and re-asserts afterwards → grant order 0,1,0,1; count increments 1 per transaction.
- Boundary reject (WRAP_EN=0):
  - count=7, up request → rej asserted, count stays 7, full=1.
  - count=0, down request → rej asserted, count stays 0, empty=1.
- Wrap (WRAP_EN=1):
  - count=7, up → count=0, wrap pulses exactly 1 cycle.
  - count=0, down → count=7, wrap pulses exactly 1 cycle.
- Reset mid-GNT: rst=0 while gnt[1]=1 and count=5 → next cycle count=0, gnt=0, state IDLE. The held req[1] is re-arbitrated only after rst=1.
